adc_rr_scheduler: RTL and testbench

- Shares one LTC2315-style serial ADC (CS/SCK/SDO, 12-bit, continuous SCK) between NREQ requesters, e.g. the twin circuits under test.
- Generates SCK from the 50 MHz clk, runs complete CS frames, and shifts in 12 bits MSB first.
- Returns each result tagged with the requester index.
- Arbitration is round-robin, so neither twin can starve the other.

---
 rtl/adc_rr_scheduler.sv | 164 ++++++++++++++++
 tb/tb_adc_rr_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_rr_scheduler.sv
// Round-robin scheduler that shares one continuous-SCK serial ADC between NREQ requesters.
// Optional ADC_SCHED_AVG_EN: each grant runs four frames and returns their truncated mean.
module adc_rr_scheduler #(
    parameter int NREQ    = 2,
    parameter int CLK_DIV = 20,
    parameter int NBITS   = 12,
    parameter int GAP_CYC = 2,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic             SDO,
    output logic             SCK,
    output logic             CS,
    output logic [NREQ-1:0]  grant,
    output logic [NREQ-1:0]  done,
    output logic [NBITS-1:0] data,
    output logic [IDW-1:0]   data_id
);

    localparam int DW = $clog2(CLK_DIV);
    localparam int XW = $clog2(NBITS + 5);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_GAP} state_t;

    state_t           r_state;
    logic [DW-1:0]    r_div;
    logic [XW-1:0]    r_idx;
    logic [GW-1:0]    r_gap;
    logic [NBITS-1:0] r_sh;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;

`ifdef ADC_SCHED_AVG_EN
    logic [1:0]       r_frame;
    logic [NBITS+1:0] r_acc;
    logic [NBITS+1:0] w_sum;
    assign w_sum = r_acc + {2'b00, r_sh};
`endif

    logic           w_tick;
    logic           w_any;
    logic [IDW-1:0] w_pick;
    logic           w_go;
    logic [IDW-1:0] w_go_id;
    logic [IDW-1:0] w_ptr_next;

    assign w_tick     = (r_div == '0);
    assign w_ptr_next = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;

    // Scan downward so the requester closest to the pointer is the last writer and wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_any  = 1'b0;
        w_pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(r_ptr) + i) % NREQ]) begin
                w_any  = 1'b1;
                w_pick = IDW'((int'(r_ptr) + i) % NREQ);
            end
        end
    end

    always_comb begin
        w_go    = 1'b0;
        w_go_id = w_pick;
        if (w_tick) begin
            if (r_state == S_IDLE) begin
                w_go = w_any;
            end else if (r_state == S_GAP && r_gap == GW'(GAP_CYC - 1)) begin
                w_go = w_any;
`ifdef ADC_SCHED_AVG_EN
                if (r_frame != 2'd0) begin
                    w_go    = 1'b1;
                    w_go_id = r_id;
                end
`endif
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_idx   <= '0;
            r_gap   <= '0;
            r_sh    <= '0;
            r_ptr   <= '0;
            r_id    <= '0;
            SCK     <= 1'b0;
            CS      <= 1'b1;
            grant   <= '0;
            done    <= '0;
            data    <= '0;
            data_id <= '0;
`ifdef ADC_SCHED_AVG_EN
            r_frame <= '0;
            r_acc   <= '0;
`endif
        end else begin
            r_div <= (r_div == DW'(CLK_DIV - 1)) ? '0 : r_div + 1'b1;
            if (w_tick)
                SCK <= 1'b1;
            else if (r_div == DW'(CLK_DIV / 2))
                SCK <= 1'b0;
            done <= '0;

            if (w_go) begin
                r_id    <= w_go_id;
                grant   <= NREQ'(1) << w_go_id;
                CS      <= 1'b0;
                r_idx   <= '0;
                r_state <= S_CONV;
            end else if (w_tick) begin
                case (r_state)
                    S_IDLE: r_state <= S_IDLE;
                    S_CONV: begin
                        // r_idx = SCK periods completed since CS fell; the frame closes on the 16th tick.
                        r_idx <= r_idx + 1'b1;
                        if (r_idx >= XW'(2) && r_idx <= XW'(NBITS + 1))
                            r_sh <= {r_sh[NBITS-2:0], SDO};
                        if (r_idx == XW'(NBITS + 3)) begin
                            CS      <= 1'b1;
                            r_gap   <= '0;
                            r_state <= S_GAP;
`ifdef ADC_SCHED_AVG_EN
                            if (r_frame == 2'd3) begin
                                data    <= w_sum[NBITS+1:2];
                                data_id <= r_id;
                                done    <= NREQ'(1) << r_id;
                                grant   <= '0;
                                r_ptr   <= w_ptr_next;
                                r_frame <= '0;
                                r_acc   <= '0;
                            end else begin
                                r_acc   <= w_sum;
                                r_frame <= r_frame + 1'b1;
                            end
`else
                            data    <= r_sh;
                            data_id <= r_id;
                            done    <= NREQ'(1) << r_id;
                            grant   <= '0;
                            r_ptr   <= w_ptr_next;
`endif
                        end
                    end
                    S_GAP: begin
                        if (r_gap == GW'(GAP_CYC - 1))
                            r_state <= S_IDLE;
                        else
                            r_gap <= r_gap + 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_rr_scheduler.sv
// Directed bench for adc_rr_scheduler with a behavioural ADC that drives SDO on SCK falling edges.
// Build with ADC_SCHED_AVG_EN defined to exercise the four-frame averaging mode.
`timescale 1ns/1ps
module tb_adc_rr_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = 2'b00;
    logic        SDO = 1'b0;
    logic        SCK;
    logic        CS;
    logic [1:0]  grant;
    logic [1:0]  done;
    logic [11:0] data;
    logic [0:0]  data_id;

    adc_rr_scheduler #(.NREQ(2), .CLK_DIV(20), .NBITS(12), .GAP_CYC(2)) dut (
        .clk(clk), .rst(rst), .req(req), .SDO(SDO), .SCK(SCK), .CS(CS),
        .grant(grant), .done(done), .data(data), .data_id(data_id)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ADC model: after the k-th SCK fall in a frame it presents the bit sampled on tick k.
    logic [11:0] code_tab [2];
    logic [11:0] cur_code = '0;
    int          n_fall = 0;
    int          frames_seen = 0;
    bit          inc_en = 1'b0;

    always @(negedge SCK) begin
        if (!CS && rst) begin
            n_fall++;
            if (n_fall == 1) begin
                cur_code = (grant[1] ? code_tab[1] : code_tab[0]) + (inc_en ? 12'(frames_seen) : 12'd0);
                frames_seen++;
            end
            SDO = (n_fall >= 3 && n_fall <= 14) ? cur_code[14 - n_fall] : 1'b0;
        end
    end

    always @(posedge CS or negedge rst) n_fall = 0;

    task automatic do_reset(input logic [1:0] r);
        @(negedge clk);
        rst = 1'b0;
        req = 2'b00;
        repeat (3) @(negedge clk);
        req = r;
        rst = 1'b1;
    endtask

    task automatic wait_cs_fall(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (CS !== 1'b0 && cyc < 2000);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done === 2'b00 && cyc < 2000);
    endtask

    initial begin
        int c;
        int h;
        int l;
        int lows;
        code_tab[0] = 12'hA5C;
        code_tab[1] = 12'h222;

        repeat (3) @(negedge clk);
        check("rst_sck", SCK, 0);
        check("rst_cs", CS, 1);
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_data", data, 0);
        check("rst_data_id", data_id, 0);

`ifdef ADC_SCHED_AVG_EN
        begin
            int falls;
            int gbad;
            logic prev;
            code_tab[0] = 12'd100;
            inc_en = 1'b1;
            frames_seen = 0;
            do_reset(2'b01);
            falls = 0; gbad = 0; prev = 1'b1; c = 0;
            while (c < 3000) begin
                @(negedge clk);
                c++;
                if (done !== 2'b00) break;
                if (prev && !CS) falls++;
                prev = CS;
                if (falls > 0 && grant !== 2'b01) gbad++;
            end
            check("avg_done", done, 2'b01);
            check("avg_data", data, 101);
            check("avg_id", data_id, 0);
            check("avg_frames", falls, 4);
            check("avg_grant_held", gbad, 0);
            check("avg_latency", c, 1 + 3 * 360 + 320);
            req = 2'b00;
        end
`else
        // single requester: latency, data and SCK shape
        rst = 1'b1;
        req = 2'b01;
        rst = 1'b0;
        do_reset(2'b01);
        wait_cs_fall(c);
        check("t1_cs_lat", c, 1);
        check("t1_grant", grant, 2'b01);
        wait_done(c);
        check("t1_done_lat", c, 320);
        check("t1_done", done, 2'b01);
        check("t1_data", data, 12'hA5C);
        check("t1_id", data_id, 0);
        req = 2'b00;
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        h = 0;
        while (SCK !== 1'b0 && h < 100) begin @(negedge clk); h++; end
        h = 0;
        while (SCK !== 1'b1 && h < 100) begin @(negedge clk); h++; end
        h = 0;
        while (SCK === 1'b1 && h < 100) begin h++; @(negedge clk); end
        l = 0;
        while (SCK === 1'b0 && l < 100) begin l++; @(negedge clk); end
        check("t1_sck_high", h, 10);
        check("t1_sck_low", l, 10);

        // both requesting: strict alternation, 18 SCK periods between frame starts
        code_tab[0] = 12'h111;
        code_tab[1] = 12'h222;
        do_reset(2'b11);
        for (int f = 0; f < 4; f++) begin
            wait_cs_fall(c);
            check($sformatf("t2_start%0d", f), c, (f == 0) ? 1 : 40);
            wait_done(c);
            check($sformatf("t2_lat%0d", f), c, 320);
            check($sformatf("t2_done%0d", f), done, (f % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("t2_data%0d", f), data, (f % 2 == 0) ? 12'h111 : 12'h222);
            check($sformatf("t2_id%0d", f), data_id, f % 2);
        end
        req = 2'b00;

        // id1 alone, id0 joins mid-frame and gets the next grant
        do_reset(2'b10);
        wait_cs_fall(c);
        check("t3_grant1", grant, 2'b10);
        repeat (100) @(negedge clk);
        req = 2'b11;
        wait_done(c);
        check("t3_lat1", c, 220);
        check("t3_done1", done, 2'b10);
        check("t3_data1", data, 12'h222);
        wait_cs_fall(c);
        check("t3_gap", c, 40);
        check("t3_grant0", grant, 2'b01);
        wait_done(c);
        check("t3_done0", done, 2'b01);
        check("t3_data0", data, 12'h111);
        req = 2'b00;

        // reset asserted around index 7, then a clean frame
        code_tab[0] = 12'hA5C;
        do_reset(2'b01);
        wait_cs_fall(c);
        repeat (145) @(negedge clk);
        check("t4_sck_pre", SCK, 1);
        #3 rst = 1'b0;
        #1;
        check("t4_cs", CS, 1);
        check("t4_sck", SCK, 0);
        check("t4_done", done, 0);
        check("t4_grant", grant, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        wait_cs_fall(c);
        check("t4_restart", c, 1);
        wait_done(c);
        check("t4_lat", c, 320);
        check("t4_data", data, 12'hA5C);

        // req dropped mid-frame: frame still completes, nothing follows
        req = 2'b00;
        do_reset(2'b01);
        wait_cs_fall(c);
        repeat (100) @(negedge clk);
        req = 2'b00;
        wait_done(c);
        check("t5_lat", c, 220);
        check("t5_done", done, 2'b01);
        check("t5_data", data, 12'hA5C);
        lows = 0;
        repeat (1000) begin
            @(negedge clk);
            if (CS !== 1'b1) lows++;
        end
        check("t5_no_frame", lows, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
